int_vector_ctrl: RTL
====================

Name: int_vector_ctrl

Overview:
- Interrupt/vector controller that drives the CPU's interrupt input and entry-point input. The CPU PC-select logic consumes both.
- After reset it issues the boot vector. After that it edge-detects external IRQ lines, latches them as pending, prioritises them, and dispatches one vector at a time.
- It blocks further dispatch until the CPU signals return-from-interrupt.
- A small register port configures the mask and enable, and clears pending bits.

Parameters:
- N_SRC, 8: number of IRQ sources, 1..16.
- RESET_ENTRY, 128: entry point issued after reset.
- VEC_BASE, 32'h200: address of vector 0.
- VEC_STRIDE, 16: byte spacing between vectors.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- irq  in  N_SRC  external interrupt requests; rising-edge sensitive.
- eret  in  1  one-cycle pulse from CPU: return from current handler.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  config register select.
- cfg_wdata  in  32  config write data.
- cfg_rdata  out  32  config read data; combinational from cfg_addr.
- INT  out  1  interrupt/redirect pulse to CPU PC mux; registered.
- entryPoint  out  32  redirect target, valid while INT=1; registered.
- in_service  out  1  high while a handler is active.
- active_id  out  4  index of the source being serviced.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. clk and reset are the only clock/reset ports.
- Reset values:
  - State=BOOT, INT=0, entryPoint=RESET_ENTRY.
  - pending=0, mask=0, enable=0, in_service=0, active_id=0.
  - irq_prev=0, so a line already high when reset releases counts as an edge.
- Edge detect: irq_prev<=irq every cycle. rise = irq & ~irq_prev. pending |= rise.
- States:
  - BOOT: on the first edge with reset=0, INT<=1, entryPoint<=RESET_ENTRY, go to BOOTFIRE.
  - BOOTFIRE: INT<=0, go to IDLE. The boot pulse is exactly one cycle and leaves in_service=0.
  - IDLE: if enable and (pending & mask)!=0:
    - id = lowest set index.
    - INT<=1, entryPoint<=VEC_BASE + id*VEC_STRIDE (32-bit, wraps mod 2^32).
    - active_id<=id, pending[id]<=0, go to FIRE.
  - FIRE: INT<=0, in_service<=1, go to SERVICE.
  - SERVICE: on eret=1, in_service<=0, go to IDLE. New dispatch is possible on the following edge.
- entryPoint holds its last value when INT=0.
- Latency: irq rises and is sampled at edge t, so pending is set after t. In IDLE, INT is high for the cycle after edge t+1 and low after edge t+2.
- Config registers; writes take effect at the clock edge:
  - addr0 mask[N_SRC-1:0], R/W.
  - addr1 enable bit0, R/W.
  - addr2 pending: read value; write-1-to-clear.
  - addr3 status: read-only {active_id at [7:4], in_service at [0]}.
  - Unused read bits = 0. Writes to addr3 are ignored.
- Boundary rules:
  - Set and clear of the same pending bit in the same cycle (new rise vs W1C or vs dispatch): set wins.
  - A rise on the currently active source while in SERVICE re-pends that source.
  - Pending accumulates in every state. A repeat edge on an already-pending source is merged.
  - eret outside SERVICE (including FIRE and BOOT states) is ignored.
  - mask/enable written in the same cycle as an IDLE evaluation: the evaluation uses the pre-write values.
  - Clearing enable during SERVICE does not end service. It blocks only the next dispatch.
  - Reset in any state, including mid-FIRE or SERVICE, returns everything to reset values and re-issues the boot pulse.

Test Plan:
- Boot: hold reset 3 cycles, release → INT=1 for exactly one cycle with entryPoint=128, then INT=0; pending=0, in_service=0.
- Single IRQ: enable=1, mask=0xFF, raise irq[3] → INT one cycle with entryPoint=0x230; then in_service=1, active_id=3, pending=0x00, status read=0x31.
- Priority and eret: irq[5] and irq[2] rise on the same edge → dispatch entryPoint=0x220. Pulse eret → in_service drops, next dispatch entryPoint=0x250. No INT pulse occurs between the two eret gaps.
- Masking: mask=0x01, raise irq[4] → no INT, pending=0x10. Write mask=0x10 → INT with entryPoint=0x240 two edges later.
- W1C collision: pending=0x30, write 0x10 to addr2 → pending=0x20. Repeat the W1C of bit4 while irq[4] rises on the same edge → pending=0x30 (set wins).
- Reset mid-service: while in SERVICE with id=3, assert reset one cycle → mask=0, enable=0, in_service=0, INT boot pulse with entryPoint=128. A later eret has no effect.

Source files
------------

// File: rtl/int_vector_ctrl.sv
// Interrupt/vector controller: issues the boot vector after reset, then edge-detects IRQ lines,
// latches them as pending and dispatches the lowest-numbered enabled source one at a time.
module int_vector_ctrl #(
  parameter int unsigned N_SRC       = 8,
  parameter logic [31:0] RESET_ENTRY = 32'd128,
  parameter logic [31:0] VEC_BASE    = 32'h200,
  parameter logic [31:0] VEC_STRIDE  = 32'd16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq,
  input  logic             eret,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             INT,
  output logic [31:0]      entryPoint,
  output logic             in_service,
  output logic [3:0]       active_id
);

  typedef enum logic [2:0] {StBoot, StBootFire, StIdle, StFire, StService} stateT;

  stateT            stateQ, stateD;
  logic             intQ, intD;
  logic [31:0]      entryQ, entryD;
  logic [N_SRC-1:0] pendingQ, pendingD;
  logic [N_SRC-1:0] maskQ, maskD;
  logic             enableQ, enableD;
  logic             inServiceQ, inServiceD;
  logic [3:0]       activeIdQ, activeIdD;
  logic [N_SRC-1:0] irqPrevQ;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] candidates;
  logic [N_SRC-1:0] lowOneHot;
  logic [N_SRC-1:0] w1cClr;
  logic [N_SRC-1:0] dispatchClr;
  logic [3:0]       lowId;
  logic             unusedWdata;

  assign unusedWdata = ^cfg_wdata;
  assign rise        = irq & ~irqPrevQ;
  assign candidates  = pendingQ & maskQ;

  // Lowest set index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    lowId     = '0;
    lowOneHot = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        lowId        = 4'(i);
        lowOneHot    = '0;
        lowOneHot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    maskD   = maskQ;
    enableD = enableQ;
    w1cClr  = '0;
    if (cfg_we) begin
      case (cfg_addr)
        2'd0:    maskD   = cfg_wdata[N_SRC-1:0];
        2'd1:    enableD = cfg_wdata[0];
        2'd2:    w1cClr  = cfg_wdata[N_SRC-1:0];
        default: ;
      endcase
    end
  end

  // Dispatch decisions use the registered mask/enable, so same-cycle writes land afterwards.
  always_comb begin
    stateD      = stateQ;
    intD        = 1'b0;
    entryD      = entryQ;
    inServiceD  = inServiceQ;
    activeIdD   = activeIdQ;
    dispatchClr = '0;
    case (stateQ)
      StBoot: begin
        intD   = 1'b1;
        entryD = RESET_ENTRY;
        stateD = StBootFire;
      end
      StBootFire: stateD = StIdle;
      StIdle: begin
        if (enableQ && (candidates != '0)) begin
          intD        = 1'b1;
          entryD      = VEC_BASE + 32'(lowId) * VEC_STRIDE;
          activeIdD   = lowId;
          dispatchClr = lowOneHot;
          stateD      = StFire;
        end
      end
      StFire: begin
        inServiceD = 1'b1;
        stateD     = StService;
      end
      StService: begin
        if (eret) begin
          inServiceD = 1'b0;
          stateD     = StIdle;
        end
      end
      default: stateD = StBoot;
    endcase
    // A fresh rise beats any clear of the same bit.
    pendingD = (pendingQ & ~(w1cClr | dispatchClr)) | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= StBoot;
      intQ       <= 1'b0;
      entryQ     <= RESET_ENTRY;
      pendingQ   <= '0;
      maskQ      <= '0;
      enableQ    <= 1'b0;
      inServiceQ <= 1'b0;
      activeIdQ  <= '0;
      irqPrevQ   <= '0;
    end else begin
      stateQ     <= stateD;
      intQ       <= intD;
      entryQ     <= entryD;
      pendingQ   <= pendingD;
      maskQ      <= maskD;
      enableQ    <= enableD;
      inServiceQ <= inServiceD;
      activeIdQ  <= activeIdD;
      irqPrevQ   <= irq;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata[N_SRC-1:0] = maskQ;
      2'd1: cfg_rdata[0]         = enableQ;
      2'd2: cfg_rdata[N_SRC-1:0] = pendingQ;
      2'd3: begin
        cfg_rdata[7:4] = activeIdQ;
        cfg_rdata[0]   = inServiceQ;
      end
      default: ;
    endcase
  end

  assign INT        = intQ;
  assign entryPoint = entryQ;
  assign in_service = inServiceQ;
  assign active_id  = activeIdQ;

endmodule
